ghash_accum: RTL
================

GHASH_ACCUM -- requirements
Module: ghash_accum

Interface
REQ-001 The block SHALL have parameter none; GF(2^128) polynomial fixed at x^128+x^7+x^2+x+1, GCM bit order (bit 127 = coefficient of x^0).
REQ-002 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port iHashkey  input  128  hash subkey H.
REQ-005 The block SHALL have port iHkeyLoad  input  1  latch iHashkey and clear accumulator Y.
REQ-006 The block SHALL have port iBlock  input  128  data block X (AAD, ciphertext or length block).
REQ-007 The block SHALL have port iValid  input  1  iBlock is offered.
REQ-008 The block SHALL have port oReady  output  1  block can accept iBlock this cycle.
REQ-009 The block SHALL have port iLast  input  1  qualifies iBlock as the final block of the message.
REQ-010 The block SHALL have port oTag  output  128  GHASH result Y after the last block.
REQ-011 The block SHALL have port oTagValid  output  1  one-cycle pulse, oTag valid.

Function
REQ-012 Per accepted block, the block SHALL compute Y <= (Y xor X) * H in GF(2^128).
REQ-013 The multiply SHALL be bit-serial: Z=0, V=Y^X; for i=0..127: if H bit(127-i) then Z^=V; V = V>>1, xor E1000000_00000000_00000000_00000000 if shifted-out bit was 1.
REQ-014 States SHALL be IDLE, MUL, DONE. Transitions: IDLE->MUL on iValid&oReady; MUL->IDLE after 128 cycles if !last; MUL->DONE after 128 cycles if last; DONE->IDLE after 1 cycle.
REQ-015 oReady SHALL be high only in IDLE and never depend combinationally on iValid.
REQ-016 Handshake: a block SHALL be accepted exactly in the cycle iValid&oReady; iBlock and iLast are sampled then.
REQ-017 Latency: Y SHALL be updated 128 cycles after acceptance; oReady SHALL return high in cycle 129 for non-last blocks.
REQ-018 For a last block, oTag SHALL equal the new Y and oTagValid SHALL pulse in DONE (cycle 129); Y SHALL then clear to 0; oReady SHALL return high in cycle 130.
REQ-019 oTag SHALL hold its value until the next oTagValid; it SHALL not change during MUL.
REQ-020 iHkeyLoad SHALL be honoured only in IDLE; it loads H and clears Y, and takes priority over a simultaneous iValid (block not accepted, oReady low that cycle).
REQ-021 iHkeyLoad and iValid in MUL or DONE SHALL be ignored; H SHALL stay stable for a whole multiply.
REQ-022 A single-block message (iLast on first block) SHALL be legal; Y starts from 0.

Reset
REQ-023 On rst_n low, asynchronously: state=IDLE, Y=0, H=0, Z=V=0, counter=0, oTag=0, oTagValid=0; oReady=1 after release.
REQ-024 Reset mid-MUL SHALL abort the block with no oTagValid; the accumulation is lost.

Structure
REQ-025 A shared package SHALL hold the state encoding, GF_R constant (E1 followed by 120 zeros) and width constant 128.
REQ-026 The bit-serial multiplier (Z, V, 7-bit counter, done flag) SHALL be the sub-module gf128_serial_mul; ghash_accum holds H, Y, FSM and handshake.

Verification
REQ-027 H=80000000..0 (unity), one last block X=92cdf2c2ef434ea04ee66cc2189c7c1e -> oTag=92cdf2c2ef434ea04ee66cc2189c7c1e, oTagValid at cycle 129.
REQ-028 H=40000000..0 (x), X=00000000..01 (x^127), last -> oTag=e1000000000000000000000000000000.
REQ-029 H=unity, two blocks 0f..0f then f0..f0 (last) -> oTag=ff..ff; oReady low exactly 128 cycles for block 1, 129 for block 2.
REQ-030 H=b83b533708bf535d0aa6e52980d53b78, X=92cdf2c2ef434ea04ee66cc2189c7c1e, last -> oTag equals gfmul single-cycle multiplier result for the same operands.
REQ-031 iValid held high during MUL plus iHkeyLoad pulsed mid-MUL -> no extra acceptance, H unchanged, tag as REQ-027.
REQ-032 rst_n asserted at MUL cycle 60 -> no oTagValid, oTag=0, next message from Y=0 produces correct tag.

Source files
------------

// File: rtl/ghash_accum_pkg.sv
// Shared definitions for the GHASH accumulator: field width, reduction
// constant, FSM encoding and the single-bit shift/reduce step.
package ghash_accum_pkg;

    localparam int GF_W = 128;

    // Reduction constant for x^128 + x^7 + x^2 + x + 1 in GCM bit order
    // (bit 127 holds the x^0 coefficient).
    localparam logic [GF_W-1:0] GF_R = {8'hE1, 120'h0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } ghashStateT;

    // Multiply V by x: a right shift in GCM bit order, folding the
    // x^128 overflow back in with GF_R.
    function automatic logic [GF_W-1:0] gfShiftStep(input logic [GF_W-1:0] v);
        return (v >> 1) ^ (v[0] ? GF_R : '0);
    endfunction

endpackage

// File: rtl/gf128_serial_mul.sv
// Bit-serial GF(2^128) multiplier, one bit of H per clock. A down-counter
// walks the H bits from index 127 (x^0) to index 0 (x^127); the terminal
// count marks the final step, whose result is presented combinationally.
module gf128_serial_mul
    import ghash_accum_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iStart,
    input  logic [GF_W-1:0] iOpV,
    input  logic [GF_W-1:0] iOpH,
    output logic            oDone,
    output logic [GF_W-1:0] oResult
);

    logic [GF_W-1:0] zAcc;
    logic [GF_W-1:0] vAcc;
    logic [6:0]      bitCnt;
    logic            busy;
    logic [GF_W-1:0] zNext;

    // Conditional accumulate of V for the current H bit.
    always_comb begin
        zNext = iOpH[bitCnt] ? (zAcc ^ vAcc) : zAcc;
    end

    assign oDone   = busy && (bitCnt == 7'd0);
    assign oResult = zNext;

    // Load operands on start, then one shift/accumulate step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zAcc   <= '0;
            vAcc   <= '0;
            bitCnt <= 7'd0;
            busy   <= 1'b0;
        end else if (iStart) begin
            zAcc   <= '0;
            vAcc   <= iOpV;
            bitCnt <= 7'd127;
            busy   <= 1'b1;
        end else if (busy) begin
            zAcc <= zNext;
            vAcc <= gfShiftStep(vAcc);
            if (bitCnt == 7'd0) begin
                busy <= 1'b0;
            end else begin
                bitCnt <= bitCnt - 7'd1;
            end
        end
    end

endmodule

// File: rtl/ghash_accum.sv
// GHASH accumulator: Y <= (Y ^ X) * H per accepted block, tag emitted
// after the block flagged last.
//
//   state | meaning
//   IDLE  | ready for a block or a hash-key load
//   MUL   | serial multiply in progress (128 cycles), inputs ignored
//   DONE  | tag pulse cycle after a last block; Y clears
module ghash_accum
    import ghash_accum_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [GF_W-1:0] iHashkey,
    input  logic            iHkeyLoad,
    input  logic [GF_W-1:0] iBlock,
    input  logic            iValid,
    output logic            oReady,
    input  logic            iLast,
    output logic [GF_W-1:0] oTag,
    output logic            oTagValid
);

    ghashStateT      state;
    logic [GF_W-1:0] hashKey;
    logic [GF_W-1:0] yAcc;
    logic            lastQ;
    logic            accept;
    logic            mulDone;
    logic [GF_W-1:0] mulResult;

    // A key load in IDLE wins over a block offer, so it also drops ready.
    assign oReady = (state == IDLE) && !iHkeyLoad;
    assign accept = iValid && oReady;

    gf128_serial_mul uMul (
        .clk     (clk),
        .rst_n   (rst_n),
        .iStart  (accept),
        .iOpV    (yAcc ^ iBlock),
        .iOpH    (hashKey),
        .oDone   (mulDone),
        .oResult (mulResult)
    );

    // Sequencing of key load, block acceptance, accumulate and tag output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hashKey   <= '0;
            yAcc      <= '0;
            lastQ     <= 1'b0;
            oTag      <= '0;
            oTagValid <= 1'b0;
        end else begin
            oTagValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (iHkeyLoad) begin
                        hashKey <= iHashkey;
                        yAcc    <= '0;
                    end else if (accept) begin
                        lastQ <= iLast;
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (mulDone) begin
                        yAcc <= mulResult;
                        if (lastQ) begin
                            oTag      <= mulResult;
                            oTagValid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    yAcc  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
